// File: rtl/driver_pkg.sv
// Shared command codes, error bit positions and the decoded-command type for
// the LED-driver receive model.
package driver_pkg;

    localparam int GS_WORD_W = 48;

    localparam logic [4:0] WRTGS     = 5'd1;
    localparam logic [4:0] LATGS     = 5'd3;
    localparam logic [4:0] WRTFC     = 5'd5;
    localparam logic [4:0] LINERESET = 5'd7;
    localparam logic [4:0] FCWRTEN   = 5'd15;

    localparam int ERR_UNKNOWN    = 0;
    localparam int ERR_FC_LOCKED  = 1;
    localparam int ERR_WORD_COUNT = 2;
    localparam int ERR_OVERFLOW   = 3;

    typedef enum logic [2:0] {
        CMD_NONE,
        CMD_WRTGS,
        CMD_LATGS,
        CMD_WRTFC,
        CMD_LINERESET,
        CMD_FCWRTEN,
        CMD_UNKNOWN
    } cmd_e;

    function automatic cmd_e decode_cmd(input logic [4:0] code);
        case (code)
            WRTGS:     return CMD_WRTGS;
            LATGS:     return CMD_LATGS;
            WRTFC:     return CMD_WRTFC;
            LINERESET: return CMD_LINERESET;
            FCWRTEN:   return CMD_FCWRTEN;
            default:   return CMD_UNKNOWN;
        endcase
    endfunction

endpackage

// File: rtl/driver_lat_decoder.sv
// Counts SCLK edges with LAT high and raises a decode strobe on the SCLK edge
// where LAT is seen falling; also registers the reported command pulse.
module driver_lat_decoder
    import driver_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk_en,
    input  logic       lat,
    output logic       dec_stb,
    output cmd_e       dec_cmd,
    output logic       cmd_valid,
    output logic [4:0] cmd_code
);

    logic       lat_q,       lat_d;
    logic [4:0] lat_cnt_q,   lat_cnt_d;
    logic       cmd_valid_q, cmd_valid_d;
    logic [4:0] cmd_code_q,  cmd_code_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_q       <= 1'b0;
            lat_cnt_q   <= '0;
            cmd_valid_q <= 1'b0;
            cmd_code_q  <= '0;
        end else begin
            lat_q       <= lat_d;
            lat_cnt_q   <= lat_cnt_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_code_q  <= cmd_code_d;
        end
    end

    always_comb begin
        dec_stb     = sclk_en & ~lat & lat_q;
        dec_cmd     = dec_stb ? decode_cmd(lat_cnt_q) : CMD_NONE;
        lat_d       = sclk_en ? lat : lat_q;
        lat_cnt_d   = lat_cnt_q;
        if (dec_stb) begin
            lat_cnt_d = '0;
        end else if (sclk_en && lat && lat_cnt_q != 5'd31) begin
            lat_cnt_d = lat_cnt_q + 5'd1;
        end
        cmd_valid_d = dec_stb;
        cmd_code_d  = dec_stb ? lat_cnt_q : cmd_code_q;
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd_code  = cmd_code_q;

endmodule

// File: rtl/driver_rx_model.sv
// Receive model of one LED-driver lane: shift register, GS bank1/bank2,
// function-control register, frame/GCLK counters and sticky error flags.
module driver_rx_model
    import driver_pkg::*;
#(
    parameter int GS_WORDS = 9,
    parameter int CNT_W    = 16
) (
    input  logic                          clk_33,
    input  logic                          nrst,
    input  logic                          sclk_en,
    input  logic                          gclk_en,
    input  logic                          lat,
    input  logic                          sin,
    output logic [GS_WORD_W-1:0]          conf_reg,
    output logic                          conf_valid,
    output logic [GS_WORDS*GS_WORD_W-1:0] gs_bank2,
    output logic                          cmd_valid,
    output logic [4:0]                    cmd_code,
    output logic [CNT_W-1:0]              frame_count,
    output logic [CNT_W-1:0]              gclk_per_frame,
    output logic [3:0]                    err
);

    localparam int               PTR_W = $clog2(GS_WORDS);
    localparam logic [PTR_W-1:0] LAST  = PTR_W'(GS_WORDS - 1);

    logic                 dec_stb;
    cmd_e                 dec_cmd;

    logic [GS_WORD_W-1:0] sr_q,         sr_d;
    logic [GS_WORD_W-1:0] bank1_q [GS_WORDS];
    logic [GS_WORD_W-1:0] bank1_d [GS_WORDS];
    logic [GS_WORD_W-1:0] bank2_q [GS_WORDS];
    logic [GS_WORD_W-1:0] bank2_d [GS_WORDS];
    logic [PTR_W-1:0]     wr_ptr_q,     wr_ptr_d;
    logic                 fc_en_q,      fc_en_d;
    logic [GS_WORD_W-1:0] conf_q,       conf_d;
    logic                 conf_valid_q, conf_valid_d;
    logic [CNT_W-1:0]     frame_q,      frame_d;
    logic [CNT_W-1:0]     gclk_cnt_q,   gclk_cnt_d;
    logic [CNT_W-1:0]     gpf_q,        gpf_d;
    logic [3:0]           err_q,        err_d;

    driver_lat_decoder u_dec (
        .clk       (clk_33),
        .rst_n     (nrst),
        .sclk_en   (sclk_en),
        .lat       (lat),
        .dec_stb   (dec_stb),
        .dec_cmd   (dec_cmd),
        .cmd_valid (cmd_valid),
        .cmd_code  (cmd_code)
    );

    always_ff @(posedge clk_33 or negedge nrst) begin
        if (!nrst) begin
            sr_q         <= '0;
            wr_ptr_q     <= '0;
            fc_en_q      <= 1'b0;
            conf_q       <= '0;
            conf_valid_q <= 1'b0;
            frame_q      <= '0;
            gclk_cnt_q   <= '0;
            gpf_q        <= '0;
            err_q        <= '0;
            for (int i = 0; i < GS_WORDS; i++) begin
                bank1_q[i] <= '0;
                bank2_q[i] <= '0;
            end
        end else begin
            sr_q         <= sr_d;
            wr_ptr_q     <= wr_ptr_d;
            fc_en_q      <= fc_en_d;
            conf_q       <= conf_d;
            conf_valid_q <= conf_valid_d;
            frame_q      <= frame_d;
            gclk_cnt_q   <= gclk_cnt_d;
            gpf_q        <= gpf_d;
            err_q        <= err_d;
            for (int i = 0; i < GS_WORDS; i++) begin
                bank1_q[i] <= bank1_d[i];
                bank2_q[i] <= bank2_d[i];
            end
        end
    end

    always_comb begin
        sr_d         = sclk_en ? {sr_q[GS_WORD_W-2:0], sin} : sr_q;
        bank1_d      = bank1_q;
        bank2_d      = bank2_q;
        wr_ptr_d     = wr_ptr_q;
        fc_en_d      = fc_en_q;
        conf_d       = conf_q;
        conf_valid_d = conf_valid_q;
        frame_d      = frame_q;
        gpf_d        = gpf_q;
        err_d        = err_q;
        gclk_cnt_d   = gclk_cnt_q;
        if (gclk_en && gclk_cnt_q != '1) begin
            gclk_cnt_d = gclk_cnt_q + 1'b1;
        end

        // Commands act on the pre-edge shift register contents.
        case (dec_cmd)
            CMD_WRTGS: begin
                if (wr_ptr_q == LAST) begin
                    err_d[ERR_OVERFLOW] = 1'b1;
                end else begin
                    for (int i = 0; i < GS_WORDS; i++) begin
                        if (PTR_W'(i) == wr_ptr_q) bank1_d[i] = sr_q;
                    end
                    wr_ptr_d = wr_ptr_q + 1'b1;
                end
            end
            CMD_LATGS, CMD_LINERESET: begin
                for (int i = 0; i < GS_WORDS; i++) begin
                    if (PTR_W'(i) == wr_ptr_q) bank1_d[i] = sr_q;
                end
                bank2_d = bank1_d;
                if (dec_cmd == CMD_LINERESET) begin
                    for (int i = 0; i < GS_WORDS; i++) bank1_d[i] = '0;
                end
                if (wr_ptr_q != LAST) err_d[ERR_WORD_COUNT] = 1'b1;
                wr_ptr_d   = '0;
                frame_d    = frame_q + 1'b1;
                gpf_d      = gclk_cnt_q;
                gclk_cnt_d = '0;
            end
            CMD_WRTFC: begin
                if (fc_en_q) begin
                    conf_d       = sr_q;
                    conf_valid_d = 1'b1;
                    fc_en_d      = 1'b0;
                end else begin
                    err_d[ERR_FC_LOCKED] = 1'b1;
                end
            end
            CMD_FCWRTEN: fc_en_d = 1'b1;
            CMD_UNKNOWN: err_d[ERR_UNKNOWN] = 1'b1;
            default: ;
        endcase
    end

    generate
        for (genvar gi = 0; gi < GS_WORDS; gi++) begin : g_bank2
            assign gs_bank2[gi*GS_WORD_W +: GS_WORD_W] = bank2_q[gi];
        end
    endgenerate

    assign conf_reg       = conf_q;
    assign conf_valid     = conf_valid_q;
    assign frame_count    = frame_q;
    assign gclk_per_frame = gpf_q;
    assign err            = err_q;

endmodule

// File: tb/tb_driver_rx_model.sv
// Bench for driver_rx_model: command codes go through a scoreboard queue,
// register/bank/counter state is checked per scenario.
module tb_driver_rx_model;

    localparam int GS_WORDS = 9;
    localparam int CNT_W    = 16;

    logic                   clk_33 = 1'b0;
    logic                   nrst   = 1'b0;
    logic                   sclk_en = 1'b0;
    logic                   gclk_en = 1'b0;
    logic                   lat = 1'b0;
    logic                   sin = 1'b0;
    logic [47:0]            conf_reg;
    logic                   conf_valid;
    logic [GS_WORDS*48-1:0] gs_bank2;
    logic                   cmd_valid;
    logic [4:0]             cmd_code;
    logic [CNT_W-1:0]       frame_count;
    logic [CNT_W-1:0]       gclk_per_frame;
    logic [3:0]             err;

    int total = 0;
    int bad   = 0;
    int exp_q [$];
    int valid_seen = 0;
    int m_cnt = 0;
    bit m_prev = 1'b0;

    driver_rx_model #(.GS_WORDS(GS_WORDS), .CNT_W(CNT_W)) dut (
        .clk_33         (clk_33),
        .nrst           (nrst),
        .sclk_en        (sclk_en),
        .gclk_en        (gclk_en),
        .lat            (lat),
        .sin            (sin),
        .conf_reg       (conf_reg),
        .conf_valid     (conf_valid),
        .gs_bank2       (gs_bank2),
        .cmd_valid      (cmd_valid),
        .cmd_code       (cmd_code),
        .frame_count    (frame_count),
        .gclk_per_frame (gclk_per_frame),
        .err            (err)
    );

    always #5 clk_33 = ~clk_33;

    // Scoreboard: every reported command must match the oldest expected code.
    always @(negedge clk_33) begin
        if (cmd_valid) begin
            valid_seen++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL cmd_unexpected: got code %0d, none expected", cmd_code);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (cmd_code !== 5'(e)) begin
                    bad++;
                    $display("FAIL cmd_code: got %0d expected %0d", cmd_code, e);
                end else begin
                    $display("cmd code=%0d ok", cmd_code);
                end
            end
        end
    end

    task automatic do_reset();
        sclk_en = 0; gclk_en = 0; lat = 0; sin = 0;
        nrst = 0;
        m_cnt = 0; m_prev = 0;
        exp_q.delete();
        repeat (2) @(posedge clk_33);
        #1 nrst = 1;
    endtask

    // One SCLK edge; the bench tracks LAT edges to predict decoded commands.
    task automatic sclk_edge(input bit s, input bit l);
        sin = s; lat = l; sclk_en = 1;
        if (!l && m_prev) begin
            exp_q.push_back(m_cnt);
            m_cnt = 0;
        end else if (l && m_cnt < 31) begin
            m_cnt++;
        end
        m_prev = l;
        @(posedge clk_33);
        #1 sclk_en = 0;
    endtask

    task automatic send_word(input logic [47:0] w, input int lat_edges);
        for (int i = 47; i >= 0; i--) sclk_edge(w[i], i < lat_edges);
    endtask

    task automatic flush();
        sclk_edge(1'b0, 1'b0);
        repeat (3) @(posedge clk_33);
        #1;
    endtask

    task automatic check_err(input string name, input logic [3:0] exp);
        @(negedge clk_33);
        total++;
        if (err !== exp) begin
            bad++;
            $display("FAIL %s: err=%b expected %b", name, err, exp);
        end else $display("%s err=%b ok", name, err);
    endtask

    task automatic check_word(input string name, input int k, input logic [47:0] exp);
        logic [47:0] got;
        got = gs_bank2[k*48 +: 48];
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s word%0d: got %h expected %h", name, k, got, exp);
        end else $display("%s word%0d=%h ok", name, k, got);
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk_33);
        total++;
        if (conf_reg !== 0 || conf_valid !== 0 || gs_bank2 !== 0 || cmd_valid !== 0 ||
            cmd_code !== 0 || frame_count !== 0 || gclk_per_frame !== 0 || err !== 0) begin
            bad++;
            $display("FAIL reset_state: conf=%h cv=%b bank2_or=%b cmdv=%b code=%0d fc=%0d gpf=%0d err=%b, expected all 0",
                     conf_reg, conf_valid, |gs_bank2, cmd_valid, cmd_code, frame_count, gclk_per_frame, err);
        end else $display("reset state all zero ok");
    endtask

    task automatic test_conf_write();
        do_reset();
        for (int i = 0; i < 15; i++) sclk_edge(1'b0, 1'b1);
        send_word(48'hA5A5_1234_5678, 5);
        flush();
        @(negedge clk_33);
        total++;
        if (conf_reg !== 48'hA5A5_1234_5678 || conf_valid !== 1'b1) begin
            bad++;
            $display("FAIL conf_write: conf=%h valid=%b expected a5a512345678 1", conf_reg, conf_valid);
        end else $display("conf_write conf=%h ok", conf_reg);
        check_err("conf_write", 4'b0000);
    endtask

    task automatic test_conf_locked();
        do_reset();
        send_word(48'h1111_2222_3333, 5);
        flush();
        @(negedge clk_33);
        total++;
        if (conf_reg !== 0 || conf_valid !== 1'b0) begin
            bad++;
            $display("FAIL conf_locked: conf=%h valid=%b expected 0 0", conf_reg, conf_valid);
        end else $display("conf_locked conf unchanged ok");
        check_err("conf_locked", 4'b0010);
    endtask

    task automatic test_frame();
        do_reset();
        for (int k = 0; k < 8; k++) send_word(48'(k + 1), 1);
        send_word(48'd9, 3);
        flush();
        @(negedge clk_33);
        for (int k = 0; k < 9; k++) check_word("frame", k, 48'(k + 1));
        total++;
        if (frame_count !== 1) begin
            bad++;
            $display("FAIL frame_count: got %0d expected 1", frame_count);
        end else $display("frame_count=1 ok");
        check_err("frame", 4'b0000);
    endtask

    task automatic test_short_frame();
        for (int k = 0; k < 7; k++) send_word(48'h100 + 48'(k), 1);
        send_word(48'h1FF, 3);
        flush();
        @(negedge clk_33);
        check_word("short", 0, 48'h100);
        check_word("short", 7, 48'h1FF);
        check_word("short", 8, 48'd9);
        total++;
        if (frame_count !== 2) begin
            bad++;
            $display("FAIL short_frame_count: got %0d expected 2", frame_count);
        end else $display("short frame_count=2 ok");
        check_err("short", 4'b0100);
    endtask

    task automatic test_gclk_and_unknown();
        send_word(48'hABC, 3);
        flush();
        gclk_en = 1;
        repeat (512) @(posedge clk_33);
        #1 gclk_en = 0;
        send_word(48'hDEF, 3);
        flush();
        @(negedge clk_33);
        total++;
        if (gclk_per_frame !== 512 || frame_count !== 4) begin
            bad++;
            $display("FAIL gclk_per_frame: got %0d fc=%0d expected 512 4", gclk_per_frame, frame_count);
        end else $display("gclk_per_frame=512 ok");
        send_word(48'h5, 9);
        flush();
        check_err("unknown", 4'b0101);
    endtask

    task automatic test_overflow_linereset();
        do_reset();
        for (int k = 0; k < 9; k++) send_word(48'h200 + 48'(k), 1);
        flush();
        check_err("overflow", 4'b1000);
        send_word(48'h2FF, 7);
        flush();
        @(negedge clk_33);
        check_word("linereset", 0, 48'h200);
        check_word("linereset", 8, 48'h2FF);
        check_err("linereset", 4'b1000);
        send_word(48'h3AA, 3);
        flush();
        @(negedge clk_33);
        check_word("after_clear", 0, 48'h3AA);
        check_word("after_clear", 1, 48'h0);
        check_err("after_clear", 4'b1100);
    endtask

    task automatic test_reset_mid_cmd();
        int seen_before;
        do_reset();
        for (int i = 0; i < 7; i++) sclk_edge(1'b1, 1'b1);
        seen_before = valid_seen;
        nrst = 0;
        m_cnt = 0; m_prev = 0;
        @(posedge clk_33);
        #1 nrst = 1;
        for (int i = 0; i < 3; i++) sclk_edge(1'b0, 1'b0);
        repeat (3) @(posedge clk_33);
        @(negedge clk_33);
        total++;
        if (valid_seen != seen_before) begin
            bad++;
            $display("FAIL reset_mid_cmd: %0d cmd_valid pulses expected 0", valid_seen - seen_before);
        end else $display("reset_mid_cmd no command ok");
        send_word(48'h777, 5);
        flush();
        check_err("reset_mid_cmd", 4'b0010);
    endtask

    initial begin
        test_reset();
        test_conf_write();
        test_conf_locked();
        test_frame();
        test_short_frame();
        test_gclk_and_unknown();
        test_overflow_linereset();
        test_reset_mid_cmd();
        repeat (4) @(posedge clk_33);
        @(negedge clk_33);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL cmd_missing: %0d expected commands never reported", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
